// File: rtl/cla_chunked_addsub_if.sv
// Operand/result handshake bundle for cla_chunked_addsub.
// The producer/consumer side uses the master modport and the engine uses the slave modport.
// The ovf signal exists only when CLA_OVF_EN is defined.
interface cla_chunked_addsub_if #(
  parameter int WIDTH = 32
);
  // Request side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;

  // Response side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             c_out;
`ifdef CLA_OVF_EN
  logic             ovf;
`endif

`ifdef CLA_OVF_EN
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c_out, ovf
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c_out, ovf
  );
`else
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, c_out
  );
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, c_out
  );
`endif
endinterface

// File: rtl/cla_chunked_addsub.sv
// Multi-cycle chunked carry look-ahead adder/subtractor.
// - One CHUNK-bit slice is resolved per cycle. All carries inside the slice are formed in
//   parallel as sums of products of the generate and propagate terms.
// - The slice carry-out is registered and used as the carry-in of the next slice.
// - A WIDTH-bit operation therefore takes WIDTH/CHUNK cycles.
// - Subtraction is A + ~B + 1: B is inverted at acceptance and the first carry-in is set to 1.
// - WIDTH must be a multiple of CHUNK.
// - The interface instance must use the same WIDTH as this module.
// - Optional feature: define CLA_OVF_EN to add the signed-overflow output (bus.ovf).
module cla_chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  cla_chunked_addsub_if.slave bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cin_q, cin_d;
  logic             c_out_q, c_out_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             last_slice;
  int               slice_base;
  logic [CHUNK-1:0] g, p, sum;
  logic [CHUNK:0]   carry;
  logic             term;

  assign last_slice = (idx_q == LAST_IDX);
  assign slice_base = int'(idx_q) * CHUNK;

  // State register
  // NOTE: sequential state is updated with non-blocking assignments, so every flop samples
  // the values from before the edge, whatever order the always blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: IDLE -> BUSY on accept, BUSY -> DONE after the top slice, DONE -> IDLE when the result is taken
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_BUSY;
      S_BUSY:  if (last_slice)    state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state; in_ready is low in DONE, so there is no same-cycle turnaround
  always_comb begin
    bus.in_ready  = (state_q == S_IDLE);
    bus.out_valid = (state_q == S_DONE);
  end

  // Slice look-ahead: each carry is g[i-1] | p[i-1]&g[i-2] | ... | (&p[i-1:0])&cin, flattened
  always_comb begin
    g        = a_q[slice_base +: CHUNK] & b_q[slice_base +: CHUNK];
    p        = a_q[slice_base +: CHUNK] ^ b_q[slice_base +: CHUNK];
    carry    = '0;
    term     = 1'b0;
    carry[0] = cin_q;
    for (int i = 1; i <= CHUNK; i++) begin
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) begin
          term = term & p[k];
        end
        carry[i] = carry[i] | term;
      end
      term = cin_q;
      for (int k = 0; k < i; k++) begin
        term = term & p[k];
      end
      carry[i] = carry[i] | term;
    end
    sum = p ^ carry[CHUNK-1:0];
  end

  // Datapath next-state: operand capture at acceptance, in-place slice write-back while BUSY
  // NOTE: every variable gets a default at the top of the block, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    idx_d    = idx_q;
    result_d = result_q;
    c_out_d  = c_out_q;
    if (state_q == S_IDLE && bus.in_valid) begin
      a_d   = bus.a;
      b_d   = bus.b ^ {WIDTH{bus.sub}};
      cin_d = bus.sub;
      idx_d = '0;
    end else if (state_q == S_BUSY) begin
      result_d[slice_base +: CHUNK] = sum;
      cin_d = carry[CHUNK];
      if (last_slice) begin
        idx_d   = '0;
        c_out_d = carry[CHUNK];
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  // Datapath registers
  // NOTE: the operand registers are reset along with the others. This keeps the slice logic
  // free of X values after reset, and the cost is small at these widths.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      c_out_q  <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      c_out_q  <= c_out_d;
    end
  end

  assign bus.result = result_q;
  assign bus.c_out  = c_out_q;

`ifdef CLA_OVF_EN
  logic ovf_q, ovf_d;

  // Signed overflow is the carry into the MSB XOR the carry out of the MSB; it is captured with c_out
  always_comb begin
    ovf_d = ovf_q;
    if (state_q == S_BUSY && last_slice) begin
      ovf_d = carry[CHUNK] ^ carry[CHUNK-1];
    end
  end

  // Overflow flag register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`endif

endmodule
